// File: rtl/mult_pkg.sv
// Shared constants and state encoding for the shift-add multiplier controller.
package mult_pkg;

   localparam int N_BITS_DEF = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLR   = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4,
      HOLD  = 3'd5
   } mult_state_t;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for the run request. The history flop comes out of
// reset set, so a run line already high when reset releases never looks like
// a fresh press.
module rise_detect (
   input  logic Clk,
   input  logic reset_n_i,
   input  logic sig_i,
   output logic rise_o
);

   logic run_q;

   // Remember last cycle's level; reset to 1 so a held line is not an edge.
   always_ff @(posedge Clk or negedge reset_n_i) begin
      if (!reset_n_i) run_q <= 1'b1;
      else            run_q <= sig_i;
   end

   assign rise_o = sig_i & ~run_q;

endmodule

// File: rtl/mult_control.sv
// Sequencer for a signed shift-add multiplier: one ADD/SHIFT pair per
// multiplier bit, the last partial product being subtracted because the
// multiplier MSB carries negative weight.
module mult_control
   import mult_pkg::*;
#(
   parameter int N_BITS = N_BITS_DEF
) (
   input  logic Clk,
   input  logic reset_n_i,
   input  logic run_i,
   input  logic load_clear_i,
   input  logic m_i,
   output logic ld_b_o,
   output logic clr_xa_o,
   output logic add_o,
   output logic sub_o,
   output logic shift_o,
   output logic busy_o,
   output logic done_o
);

   localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_BITS - 1);

   mult_state_t state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic run_rise;

   rise_detect u_rise (
      .Clk       (Clk),
      .reset_n_i (reset_n_i),
      .sig_i     (run_i),
      .rise_o    (run_rise)
   );

   // State and iteration counter registers.
   always_ff @(posedge Clk or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state and output decode; a load request in IDLE swallows any start.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      ld_b_o     = 1'b0;
      clr_xa_o   = 1'b0;
      add_o      = 1'b0;
      sub_o      = 1'b0;
      shift_o    = 1'b0;
      busy_o     = 1'b0;
      done_o     = 1'b0;
      unique case (state)
         IDLE: begin
            ld_b_o   = load_clear_i;
            clr_xa_o = load_clear_i;
            if (run_rise && !load_clear_i) state_next = CLR;
         end
         CLR: begin
            clr_xa_o   = 1'b1;
            busy_o     = 1'b1;
            cnt_next   = '0;
            state_next = ADD;
         end
         ADD: begin
            busy_o = 1'b1;
            if (cnt == LAST) sub_o = m_i;
            else             add_o = m_i;
            state_next = SHIFT;
         end
         SHIFT: begin
            busy_o  = 1'b1;
            shift_o = 1'b1;
            if (cnt == LAST) begin
               state_next = DONE;
            end else begin
               cnt_next   = cnt + CW'(1);
               state_next = ADD;
            end
         end
         DONE: begin
            done_o     = 1'b1;
            state_next = HOLD;
         end
         HOLD: begin
            if (!run_i) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mult_control.sv
// Bench for mult_control with a behavioural X:A:B datapath closing the m_i loop.
module tb_mult_control;

   logic Clk = 1'b0;
   logic reset_n_i, run_i, load_clear_i, m_i;
   logic ld_b_o, clr_xa_o, add_o, sub_o, shift_o, busy_o, done_o;

   mult_control #(.N_BITS(8)) dut (
      .Clk          (Clk),
      .reset_n_i    (reset_n_i),
      .run_i        (run_i),
      .load_clear_i (load_clear_i),
      .m_i          (m_i),
      .ld_b_o       (ld_b_o),
      .clr_xa_o     (clr_xa_o),
      .add_o        (add_o),
      .sub_o        (sub_o),
      .shift_o      (shift_o),
      .busy_o       (busy_o),
      .done_o       (done_o)
   );

   typedef struct {
      logic [7:0]  b;
      logic [7:0]  s;
      logic [15:0] prod;
   } vec_t;

   typedef struct {
      logic [15:0] prod;
      int          adds;
      int          subs;
   } exp_t;

   int tests = 0;
   int fails = 0;

   logic [7:0] sw, dp_s, dp_a, dp_b;
   logic       dp_x;
   exp_t       sb[$];
   int         starts = 0;
   int         done_cnt = 0;
   int         lat, n_add, n_sub, n_shift;
   bit         in_run = 0;
   logic       busy_q = 1'b0;

   assign m_i = dp_b[0];

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Datapath model: B load, X/A clear, 9-bit signed add/sub, arithmetic shift.
   always @(posedge Clk) begin
      if (ld_b_o)   dp_b <= sw;
      if (clr_xa_o) begin
         dp_x <= 1'b0;
         dp_a <= 8'h00;
      end
      if (add_o) {dp_x, dp_a} <= {dp_a[7], dp_a} + {dp_s[7], dp_s};
      if (sub_o) {dp_x, dp_a} <= {dp_a[7], dp_a} - {dp_s[7], dp_s};
      if (shift_o) {dp_x, dp_a, dp_b} <= {dp_x, dp_x, dp_a, dp_b[7:1]};
   end

   // Run monitor: counts pulses per run and scores each done against the queue.
   always @(negedge Clk) begin
      if (!reset_n_i) begin
         in_run = 0;
         busy_q = 1'b0;
      end else begin
         if (busy_o && !busy_q) begin
            starts++;
            in_run  = 1;
            lat     = 0;
            n_add   = 0;
            n_sub   = 0;
            n_shift = 0;
         end else if (in_run) begin
            lat++;
         end
         if (busy_o) check("add_sub_excl", {31'd0, add_o & sub_o}, 32'd0);
         if (add_o)   n_add++;
         if (sub_o)   n_sub++;
         if (shift_o) n_shift++;
         if (done_o) begin
            done_cnt++;
            check("sb_nonempty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
            if (sb.size() > 0) begin
               exp_t e;
               e = sb.pop_front();
               check("product", {16'd0, dp_a, dp_b}, {16'd0, e.prod});
               check("add_count", n_add, e.adds);
               check("sub_count", n_sub, e.subs);
               check("shift_count", n_shift, 8);
               check("latency", lat, 17);
            end
            in_run = 0;
         end
         busy_q = busy_o;
      end
   end

   function automatic exp_t mk_exp(input logic [7:0] b, input logic [15:0] prod);
      exp_t e;
      e.prod = prod;
      e.adds = 0;
      for (int i = 0; i < 7; i++) e.adds += int'(b[i]);
      e.subs = int'(b[7]);
      return e;
   endfunction

   task automatic load_b(input logic [7:0] b, input logic [7:0] s);
      sw   = b;
      dp_s = s;
      load_clear_i = 1'b1;
      tick();
      load_clear_i = 1'b0;
   endtask

   task automatic applyStimulus(input vec_t v);
      int d0;
      load_b(v.b, v.s);
      sb.push_back(mk_exp(v.b, v.prod));
      d0 = done_cnt;
      run_i = 1'b1;
      tick();
      tick();
      run_i = 1'b0;
      for (int i = 0; i < 60 && done_cnt == d0; i++) tick();
      check("done_seen", done_cnt - d0, 1);
      repeat (3) tick();
   endtask

   function automatic logic [6:0] outs();
      return {ld_b_o, clr_xa_o, add_o, sub_o, shift_o, busy_o, done_o};
   endfunction

   vec_t vecs[8];

   initial begin
      int d0, s0;
      vecs[0] = '{8'h07, 8'hC5, 16'hFE63};
      vecs[1] = '{8'h80, 8'h03, 16'hFE80};
      vecs[2] = '{8'h00, 8'h55, 16'h0000};
      vecs[3] = '{8'hFF, 8'h01, 16'hFFFF};
      vecs[4] = '{8'h05, 8'h06, 16'h001E};
      vecs[5] = '{8'h7F, 8'h7F, 16'h3F01};
      vecs[6] = '{8'h80, 8'h80, 16'h4000};
      vecs[7] = '{8'hFE, 8'h9C, 16'h00C8};

      sw = 8'h00; dp_s = 8'h00;
      reset_n_i = 1'b0; run_i = 1'b1; load_clear_i = 1'b0;
      repeat (3) @(negedge Clk);
      #1 check("reset_outs", {25'd0, outs()}, 32'd0);

      // Run held high across reset release must not start anything.
      tick();
      reset_n_i = 1'b1;
      s0 = starts;
      repeat (8) tick();
      check("run_through_reset", starts - s0, 0);
      @(negedge Clk);
      #1 check("idle_outs", {25'd0, outs()}, 32'd0);
      run_i = 1'b0;
      tick();

      // Two-cycle load/clear in IDLE.
      load_clear_i = 1'b1;
      sw = 8'h07;
      for (int i = 0; i < 2; i++) begin
         @(negedge Clk);
         #1 check("load_clear", {29'd0, ld_b_o, clr_xa_o, busy_o}, 32'd6);
         tick();
      end
      load_clear_i = 1'b0;
      tick();

      // Table-driven multiplications.
      for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

      // Rising run together with load/clear: load wins, start discarded.
      sw = 8'h11;
      s0 = starts;
      load_clear_i = 1'b1;
      run_i = 1'b1;
      tick();
      load_clear_i = 1'b0;
      repeat (6) tick();
      check("load_beats_start", starts - s0, 0);
      run_i = 1'b0;
      tick();

      // Run held for 40 cycles yields exactly one multiplication.
      load_b(8'h03, 8'h04);
      sb.push_back(mk_exp(8'h03, 16'h000C));
      d0 = done_cnt;
      s0 = starts;
      run_i = 1'b1;
      repeat (40) tick();
      check("held_done_once", done_cnt - d0, 1);
      check("held_start_once", starts - s0, 1);
      run_i = 1'b0;
      repeat (2) tick();
      applyStimulus(vecs[4]);

      // Asynchronous reset in the middle of ADD with cnt=3.
      load_b(8'h5A, 8'h21);
      sb.push_back(mk_exp(8'h5A, 16'h0000));
      s0 = starts;
      run_i = 1'b1;
      for (int i = 0; i < 10 && starts == s0; i++) begin
         @(negedge Clk);
         #1;
      end
      check("mid_run_started", starts - s0, 1);
      repeat (7) @(negedge Clk);
      #1 check("at_add3_busy", {31'd0, busy_o}, 32'd1);
      #1 reset_n_i = 1'b0;
      #1 check("async_reset_outs", {25'd0, outs()}, 32'd0);
      sb.delete();
      run_i = 1'b0;
      repeat (2) tick();
      reset_n_i = 1'b1;
      tick();
      applyStimulus(vecs[0]);

      check("sb_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
